// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the RV32 memory-access stage.
// Holds funct3 codes, FSM encodings and the bus/write-back payload structs.
package mem_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 8;

    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic            req;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } bus_req_t;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
    } wb_t;

    // Context of the in-flight access, needed when the response returns.
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] waddr;
        logic [1:0]        off;
        logic [2:0]        funct3;
        logic              store;
    } acc_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic mis;
        case (funct3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store shift, misalign check,
// and load byte/halfword extraction with sign or zero extension.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]      i_st_funct3,
    input  logic [1:0]      i_st_off,
    input  logic [XLEN-1:0] i_st_wdata,
    output logic [BE_W-1:0] o_be_c,
    output logic [XLEN-1:0] o_wdata_c,
    output logic            o_misalign_c,
    input  logic [2:0]      i_ld_funct3,
    input  logic [1:0]      i_ld_off,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_ldata_c
);

    logic [2:0]      w_size;
    logic [XLEN-1:0] w_shift;

    assign w_size       = {1'b0, i_st_funct3[1:0]};
    assign o_wdata_c    = i_st_wdata << {i_st_off, 3'b000};
    assign o_misalign_c = is_misaligned(i_st_funct3, i_st_off);
    assign w_shift      = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_be_c = 4'b1111;
        case (w_size)
            SB:      o_be_c = 4'b0001 << i_st_off;
            SH:      o_be_c = 4'b0011 << i_st_off;
            SW:      o_be_c = 4'b1111;
            default: o_be_c = 4'b1111;
        endcase
    end

    always_comb begin
        o_ldata_c = i_rdata;
        case (i_ld_funct3)
            LB:      o_ldata_c = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            LH:      o_ldata_c = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
            LW:      o_ldata_c = i_rdata;
            LBU:     o_ldata_c = {{(XLEN-8){1'b0}}, w_shift[7:0]};
            LHU:     o_ldata_c = {{(XLEN-16){1'b0}}, w_shift[15:0]};
            default: o_ldata_c = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32 memory-access stage: ALU pass-through plus load/store over a
// req/gnt/rvalid bus, with upstream hold and a per-phase timeout.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_we_i,
    input  logic [REG_AW-1:0] reg_waddr_i,
    input  logic [XLEN-1:0]   reg_wdata_i,
    input  logic              mem_re_i,
    input  logic              mem_we_i,
    input  logic [XLEN-1:0]   mem_addr_i,
    input  logic [XLEN-1:0]   mem_wdata_i,
    input  logic [2:0]        mem_funct3_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              hold_req_o,
    output logic              wb_reg_we_o,
    output logic [REG_AW-1:0] wb_reg_waddr_o,
    output logic [XLEN-1:0]   wb_reg_wdata_o,
    output logic              misalign_o,
    output logic              bus_err_o
);

    mem_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    bus_req_t         r_bus, w_bus_nxt;
    wb_t              r_wb, w_wb_nxt;
    acc_t             r_acc, w_acc_nxt;
    logic             r_misalign, w_misalign_nxt;
    logic             r_bus_err, w_bus_err_nxt;

    logic             w_mem_op;
    logic             w_timeout;
    logic             w_hold;
    logic [BE_W-1:0]  w_be;
    logic [XLEN-1:0]  w_st_wdata;
    logic             w_misalign;
    logic [XLEN-1:0]  w_ldata;

    assign w_mem_op  = mem_re_i | mem_we_i;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC));

    lsu_align u_lsu_align (
        .i_st_funct3  (mem_funct3_i),
        .i_st_off     (mem_addr_i[1:0]),
        .i_st_wdata   (mem_wdata_i),
        .o_be_c       (w_be),
        .o_wdata_c    (w_st_wdata),
        .o_misalign_c (w_misalign),
        .i_ld_funct3  (r_acc.funct3),
        .i_ld_off     (r_acc.off),
        .i_rdata      (mem_rdata_i),
        .o_ldata_c    (w_ldata)
    );

    // Next-state, next-register values and the combinational hold request.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_bus_nxt      = r_bus;
        w_wb_nxt       = r_wb;
        w_wb_nxt.we    = 1'b0;
        w_acc_nxt      = r_acc;
        w_misalign_nxt = 1'b0;
        w_bus_err_nxt  = 1'b0;
        w_hold         = 1'b0;

        case (r_state)
            MEM_IDLE: begin
                if (!w_mem_op) begin
                    w_wb_nxt.we    = reg_we_i;
                    w_wb_nxt.waddr = reg_waddr_i;
                    w_wb_nxt.wdata = reg_wdata_i;
                end else if (w_misalign) begin
                    w_misalign_nxt = 1'b1;
                end else begin
                    w_hold           = 1'b1;
                    w_acc_nxt.we     = reg_we_i;
                    w_acc_nxt.waddr  = reg_waddr_i;
                    w_acc_nxt.off    = mem_addr_i[1:0];
                    w_acc_nxt.funct3 = mem_funct3_i;
                    w_acc_nxt.store  = mem_we_i;
                    w_bus_nxt.req    = 1'b1;
                    w_bus_nxt.we     = mem_we_i;
                    w_bus_nxt.addr   = {mem_addr_i[XLEN-1:2], 2'b00};
                    w_bus_nxt.be     = w_be;
                    w_bus_nxt.wdata  = mem_we_i ? w_st_wdata : ZERO_WORD;
                    w_cnt_nxt        = '0;
                    w_state_nxt      = MEM_REQ;
                end
            end

            MEM_REQ: begin
                if (w_timeout) begin
                    w_bus_err_nxt = 1'b1;
                    w_bus_nxt.req = 1'b0;
                    w_state_nxt   = MEM_IDLE;
                end else if (mem_gnt_i) begin
                    w_hold        = 1'b1;
                    w_bus_nxt.req = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = MEM_WAIT;
                end else begin
                    w_hold    = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            MEM_WAIT: begin
                if (w_timeout) begin
                    w_bus_err_nxt = 1'b1;
                    w_bus_nxt.req = 1'b0;
                    w_state_nxt   = MEM_IDLE;
                end else if (mem_rvalid_i) begin
                    if (!r_acc.store) begin
                        w_wb_nxt.we    = r_acc.we;
                        w_wb_nxt.waddr = r_acc.waddr;
                        w_wb_nxt.wdata = w_ldata;
                    end
                    w_state_nxt = MEM_IDLE;
                end else begin
                    w_hold    = 1'b1;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            default: w_state_nxt = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= MEM_IDLE;
            r_cnt      <= '0;
            r_bus      <= '0;
            r_wb       <= '0;
            r_acc      <= '0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bus      <= w_bus_nxt;
            r_wb       <= w_wb_nxt;
            r_acc      <= w_acc_nxt;
            r_misalign <= w_misalign_nxt;
            r_bus_err  <= w_bus_err_nxt;
        end
    end

    assign hold_req_o     = w_hold;
    assign mem_req_o      = r_bus.req;
    assign mem_we_o       = r_bus.we;
    assign mem_addr_o     = r_bus.addr;
    assign mem_be_o       = r_bus.be;
    assign mem_wdata_o    = r_bus.wdata;
    assign wb_reg_we_o    = r_wb.we;
    assign wb_reg_waddr_o = r_wb.waddr;
    assign wb_reg_wdata_o = r_wb.wdata;
    assign misalign_o     = r_misalign;
    assign bus_err_o      = r_bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table with a write-back
// scoreboard, plus hand sequences for timeout and reset mid-access.
module tb_mem_stage;

    localparam int unsigned TO = 4;
    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] reg_wdata_i;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [2:0]  mem_funct3_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        hold_req_o;
    logic        wb_reg_we_o;
    logic [4:0]  wb_reg_waddr_o;
    logic [31:0] wb_reg_wdata_o;
    logic        misalign_o;
    logic        bus_err_o;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        int          kind;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_bwdata;
        logic        e_wb_we;
        logic [31:0] e_wb_wdata;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    vec_t    tbl[17];

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .reg_we_i       (reg_we_i),
        .reg_waddr_i    (reg_waddr_i),
        .reg_wdata_i    (reg_wdata_i),
        .mem_re_i       (mem_re_i),
        .mem_we_i       (mem_we_i),
        .mem_addr_i     (mem_addr_i),
        .mem_wdata_i    (mem_wdata_i),
        .mem_funct3_i   (mem_funct3_i),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_be_o       (mem_be_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .hold_req_o     (hold_req_o),
        .wb_reg_we_o    (wb_reg_we_o),
        .wb_reg_waddr_o (wb_reg_waddr_o),
        .wb_reg_wdata_o (wb_reg_wdata_o),
        .misalign_o     (misalign_o),
        .bus_err_o      (bus_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reg_we_i     = 1'b0;
        reg_waddr_i  = '0;
        reg_wdata_i  = '0;
        mem_re_i     = 1'b0;
        mem_we_i     = 1'b0;
        mem_addr_i   = '0;
        mem_wdata_i  = '0;
        mem_funct3_i = '0;
    endtask

    task automatic pop_wb(input string tag);
        wb_exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL %s.sb: scoreboard empty", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, ".wb_we"}, 32'(wb_reg_we_o), 32'(e.we));
        if (e.chk_data) begin
            chk({tag, ".wb_waddr"}, 32'(wb_reg_waddr_o), 32'(e.waddr));
            chk({tag, ".wb_wdata"}, wb_reg_wdata_o, e.wdata);
        end
    endtask

    function automatic vec_t mk(input int kind, input logic we, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] a, input logic [2:0] f3,
                                input logic [31:0] rd, input int g, input int r, input logic mis,
                                input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ebw,
                                input logic ewe, input logic [31:0] ewd);
        vec_t v;
        v.kind = kind; v.we = we; v.waddr = wa; v.wdata = wd; v.addr = a; v.f3 = f3;
        v.rdata = rd; v.gnt_dly = g; v.rv_dly = r; v.mis = mis; v.e_addr = ea;
        v.e_be = ebe; v.e_bwdata = ebw; v.e_wb_we = ewe; v.e_wb_wdata = ewd;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        string   tag;
        wb_exp_t e;
        tag = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        reg_we_i     = v.we;
        reg_waddr_i  = v.waddr;
        reg_wdata_i  = (v.kind == K_ALU) ? v.wdata : $urandom;
        mem_re_i     = (v.kind == K_LD);
        mem_we_i     = (v.kind == K_ST);
        mem_addr_i   = v.addr;
        mem_wdata_i  = (v.kind == K_ST) ? v.wdata : $urandom;
        mem_funct3_i = v.f3;
        e.we       = v.e_wb_we;
        e.waddr    = v.waddr;
        e.wdata    = v.e_wb_wdata;
        e.chk_data = (v.kind == K_ALU) ? 1'b1 : (v.kind == K_LD && v.e_wb_we);
        sb_q.push_back(e);

        @(negedge clk);
        chk({tag, ".hold_idle"}, 32'(hold_req_o), 32'((v.kind != K_ALU) && !v.mis));

        if (v.kind == K_ALU || v.mis) begin
            @(posedge clk); #1;
            idle_inputs();
            @(negedge clk);
            chk({tag, ".misalign"}, 32'(misalign_o), 32'(v.mis));
            chk({tag, ".req_none"}, 32'(mem_req_o), 32'd0);
            pop_wb(tag);
            if (v.mis) begin
                @(negedge clk);
                chk({tag, ".misalign_pulse"}, 32'(misalign_o), 32'd0);
            end
        end else begin
            for (int i = 0; i <= v.gnt_dly; i++) begin
                @(posedge clk); #1;
                @(negedge clk);
                chk({tag, ".req"}, 32'(mem_req_o), 32'd1);
                chk({tag, ".hold_req"}, 32'(hold_req_o), 32'd1);
                chk({tag, ".addr"}, mem_addr_o, v.e_addr);
                chk({tag, ".be"}, 32'(mem_be_o), 32'(v.e_be));
                chk({tag, ".bus_we"}, 32'(mem_we_o), 32'(v.kind == K_ST));
                if (v.kind == K_ST) chk({tag, ".bus_wdata"}, mem_wdata_o, v.e_bwdata);
                if (i == v.gnt_dly) mem_gnt_i = 1'b1;
            end
            @(posedge clk); #1;
            mem_gnt_i = 1'b0;
            for (int j = 0; j <= v.rv_dly; j++) begin
                if (j > 0) begin
                    @(posedge clk); #1;
                end
                @(negedge clk);
                chk({tag, ".req_wait"}, 32'(mem_req_o), 32'd0);
                chk({tag, ".hold_wait"}, 32'(hold_req_o), 32'd1);
                if (j == v.rv_dly) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = v.rdata;
                    #1;
                    chk({tag, ".hold_rvalid"}, 32'(hold_req_o), 32'd0);
                end
            end
            @(posedge clk); #1;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = $urandom;
            idle_inputs();
            @(negedge clk);
            pop_wb(tag);
            chk({tag, ".req_done"}, 32'(mem_req_o), 32'd0);
            chk({tag, ".hold_done"}, 32'(hold_req_o), 32'd0);
        end
    endtask

    initial begin
        int  n_hold;
        bit  done;
        vec_t va;

        idle_inputs();
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;

        tbl[0]  = mk(K_ALU, 1, 5,  32'h1234,     32'h0,   3'b000, 32'h0,         0, 0, 0, 32'h0,   4'b0000, 32'h0,         1, 32'h1234);
        tbl[1]  = mk(K_LD,  1, 7,  32'h0,        32'h103, 3'b000, 32'h80FF_0011, 0, 0, 0, 32'h100, 4'b1000, 32'h0,         1, 32'hFFFF_FF80);
        tbl[2]  = mk(K_LD,  1, 8,  32'h0,        32'h103, 3'b100, 32'h80FF_0011, 0, 0, 0, 32'h100, 4'b1000, 32'h0,         1, 32'h0000_0080);
        tbl[3]  = mk(K_ST,  0, 0,  32'hABCD,     32'h202, 3'b001, 32'h0,         0, 0, 0, 32'h200, 4'b1100, 32'hABCD_0000, 0, 32'h0);
        tbl[4]  = mk(K_LD,  1, 4,  32'h0,        32'h101, 3'b010, 32'h0,         0, 0, 1, 32'h0,   4'b0000, 32'h0,         0, 32'h0);
        tbl[5]  = mk(K_LD,  1, 11, 32'h0,        32'h102, 3'b001, 32'h8001_7FFF, 3, 1, 0, 32'h100, 4'b1100, 32'h0,         1, 32'hFFFF_8001);
        tbl[6]  = mk(K_LD,  1, 12, 32'h0,        32'h100, 3'b101, 32'h1234_F00D, 1, 0, 0, 32'h100, 4'b0011, 32'h0,         1, 32'h0000_F00D);
        tbl[7]  = mk(K_LD,  1, 0,  32'h0,        32'h10C, 3'b010, 32'hDEAD_BEEF, 0, 2, 0, 32'h10C, 4'b1111, 32'h0,         1, 32'hDEAD_BEEF);
        tbl[8]  = mk(K_LD,  1, 13, 32'h0,        32'h201, 3'b000, 32'h0000_7F00, 0, 0, 0, 32'h200, 4'b0010, 32'h0,         1, 32'h0000_007F);
        tbl[9]  = mk(K_LD,  0, 14, 32'h0,        32'h300, 3'b010, 32'h1234_5678, 0, 0, 0, 32'h300, 4'b1111, 32'h0,         0, 32'h0);
        tbl[10] = mk(K_ST,  0, 0,  32'h1234_56A5, 32'h301, 3'b000, 32'h0,        2, 1, 0, 32'h300, 4'b0010, 32'h3456_A500, 0, 32'h0);
        tbl[11] = mk(K_ST,  0, 0,  32'hCAFE_F00D, 32'h400, 3'b010, 32'h0,        1, 2, 0, 32'h400, 4'b1111, 32'hCAFE_F00D, 0, 32'h0);
        tbl[12] = mk(K_LD,  1, 15, 32'h0,        32'h103, 3'b001, 32'h0,         0, 0, 1, 32'h0,   4'b0000, 32'h0,         0, 32'h0);
        tbl[13] = mk(K_ST,  0, 0,  32'h1111,     32'h201, 3'b001, 32'h0,         0, 0, 1, 32'h0,   4'b0000, 32'h0,         0, 32'h0);
        tbl[14] = mk(K_ST,  0, 0,  32'h2222,     32'h402, 3'b010, 32'h0,         0, 0, 1, 32'h0,   4'b0000, 32'h0,         0, 32'h0);
        tbl[15] = mk(K_ALU, 0, 3,  32'h55,       32'h0,   3'b000, 32'h0,         0, 0, 0, 32'h0,   4'b0000, 32'h0,         0, 32'h55);
        tbl[16] = mk(K_ALU, 1, 0,  32'hFFFF_FFFF, 32'h0,  3'b000, 32'h0,         0, 0, 0, 32'h0,   4'b0000, 32'h0,         1, 32'hFFFF_FFFF);

        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst.req",      32'(mem_req_o),      32'd0);
        chk("rst.we",       32'(mem_we_o),       32'd0);
        chk("rst.addr",     mem_addr_o,          32'd0);
        chk("rst.be",       32'(mem_be_o),       32'd0);
        chk("rst.wdata",    mem_wdata_o,         32'd0);
        chk("rst.wb_we",    32'(wb_reg_we_o),    32'd0);
        chk("rst.wb_waddr", 32'(wb_reg_waddr_o), 32'd0);
        chk("rst.wb_wdata", wb_reg_wdata_o,      32'd0);
        chk("rst.misalign", 32'(misalign_o),     32'd0);
        chk("rst.bus_err",  32'(bus_err_o),      32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int k = 0; k < 17; k++) run_vec(tbl[k], k);

        // Grant never arrives: abort after the timeout window.
        @(posedge clk); #1;
        reg_we_i = 1'b1; reg_waddr_i = 5'd9; mem_re_i = 1'b1;
        mem_addr_i = 32'h500; mem_funct3_i = 3'b010;
        sb_q.push_back('{we: 1'b0, waddr: 5'd9, wdata: 32'h0, chk_data: 1'b0});
        @(posedge clk); #1;
        n_hold = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (hold_req_o) begin
                n_hold++;
                if (n_hold > 20) done = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
        chk("to.hold_cycles", 32'(n_hold), 32'(TO));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("to.bus_err", 32'(bus_err_o), 32'd1);
        chk("to.req",     32'(mem_req_o), 32'd0);
        pop_wb("to");
        @(negedge clk);
        chk("to.bus_err_pulse", 32'(bus_err_o), 32'd0);
        va = mk(K_ALU, 1, 6, 32'h600D, 32'h0, 3'b000, 32'h0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 1, 32'h600D);
        run_vec(va, 100);

        // Reset lands while waiting for the response.
        @(posedge clk); #1;
        reg_we_i = 1'b1; reg_waddr_i = 5'd10; mem_re_i = 1'b1;
        mem_addr_i = 32'h604; mem_funct3_i = 3'b010;
        @(posedge clk); #1;
        @(negedge clk);
        mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        @(negedge clk);
        chk("rw.addr_pre", mem_addr_o, 32'h604);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rw.req",      32'(mem_req_o),      32'd0);
        chk("rw.we",       32'(mem_we_o),       32'd0);
        chk("rw.addr",     mem_addr_o,          32'd0);
        chk("rw.be",       32'(mem_be_o),       32'd0);
        chk("rw.wdata",    mem_wdata_o,         32'd0);
        chk("rw.wb_we",    32'(wb_reg_we_o),    32'd0);
        chk("rw.wb_waddr", 32'(wb_reg_waddr_o), 32'd0);
        chk("rw.wb_wdata", wb_reg_wdata_o,      32'd0);
        chk("rw.hold",     32'(hold_req_o),     32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_1111;
        @(posedge clk); #1;
        mem_rvalid_i = 1'b0;
        @(negedge clk);
        chk("rw.late_wb_we", 32'(wb_reg_we_o), 32'd0);
        chk("rw.late_req",   32'(mem_req_o),   32'd0);
        chk("rw.late_hold",  32'(hold_req_o),  32'd0);
        va = mk(K_ALU, 1, 2, 32'hBEEF, 32'h0, 3'b000, 32'h0, 0, 0, 0, 32'h0, 4'b0, 32'h0, 1, 32'hBEEF);
        run_vec(va, 101);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
